// File: rtl/rtc_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rtc_alarm_ctrl
// Brief   : hh:mm:ss time-of-day keeper with button editing, 12/24 h display,
//           blink enables and a timed alarm; outputs registered BCD digits.
// Revision: 1.0
// ============================================================================
module rtc_alarm_ctrl #(
    parameter int unsigned T_1S        = 25_000_000,
    parameter int unsigned T_BLINK     = 12_500_000,
    parameter int unsigned RING_S      = 60,
    parameter bit          H12_DEFAULT = 1'b0
) (
    input  logic        clk_25m,
    input  logic        rst_25m,
    input  logic        flag_adjust,
    input  logic        flag_add,
    input  logic        flag_sub,
    input  logic        flag_mode,
    input  logic        flag_alarm,
    output logic [23:0] digital_num,
    output logic        pm,
    output logic        h_blink,
    output logic        m_blink,
    output logic        s_blink,
    output logic        alarm_view,
    output logic        alarm_armed,
    output logic        alarm_ring
);

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        ADJ_H = 3'd1,
        ADJ_M = 3'd2,
        ADJ_S = 3'd3,
        AL_H  = 3'd4,
        AL_M  = 3'd5
    } state_t;

    localparam logic [31:0] c_t1s_last   = 32'(T_1S - 1);
    localparam logic [31:0] c_blink_last = 32'(T_BLINK - 1);
    localparam logic [7:0]  c_ring_load  = 8'(RING_S);
    localparam logic [23:0] c_num_rst    = H12_DEFAULT ? 24'h120000 : 24'h000000;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d, blink_cnt_q, blink_cnt_d;
    logic        half_wave_q, half_wave_d;
    logic [5:0]  sec_q, sec_d, min_q, min_d, al_min_q, al_min_d;
    logic [4:0]  hour_q, hour_d, al_hour_q, al_hour_d;
    logic        armed_q, armed_d, ring_q, ring_d, h12_q, h12_d;
    logic [7:0]  ring_cnt_q, ring_cnt_d;
    logic [23:0] num_q, num_d;
    logic        pm_q, pm_d, hb_q, hb_d, mb_q, mb_d, sb_q, sb_d;

    logic        w_adj, w_al, w_tick, w_edit, w_trigger;
    logic [4:0]  w_disp_h, w_disp_h_map;
    logic [5:0]  w_disp_m, w_disp_s;

    function automatic logic [5:0] wrap6(input logic [5:0] v, input logic up);
        if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    function automatic logic [4:0] wrap5(input logic [4:0] v, input logic up);
        if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
        return (v == 5'd0) ? 5'd23 : v - 5'd1;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] rem;
        tens = 4'd0;
        rem  = v;
        for (int k = 0; k < 5; k++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    assign w_adj  = (state_q == ADJ_H) || (state_q == ADJ_M) || (state_q == ADJ_S);
    assign w_al   = (state_q == AL_H) || (state_q == AL_M);
    assign w_tick = !w_adj && (cnt_q == c_t1s_last);
    // Adjust has priority over add/sub; add and sub together cancel.
    assign w_edit = !flag_adjust && (flag_add ^ flag_sub);

    always_comb begin
        state_d = state_q;
        if (flag_adjust) begin
            case (state_q)
                RUN:     state_d = ADJ_H;
                ADJ_H:   state_d = ADJ_M;
                ADJ_M:   state_d = ADJ_S;
                ADJ_S:   state_d = AL_H;
                AL_H:    state_d = AL_M;
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        cnt_d       = (w_adj || w_tick) ? 32'd0 : cnt_q + 32'd1;
        blink_cnt_d = blink_cnt_q + 32'd1;
        half_wave_d = half_wave_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        al_min_d    = al_min_q;
        al_hour_d   = al_hour_q;
        armed_d     = armed_q;
        ring_d      = ring_q;
        ring_cnt_d  = ring_cnt_q;
        h12_d       = flag_mode ? !h12_q : h12_q;
        w_trigger   = 1'b0;

        if (flag_adjust) begin
            blink_cnt_d = 32'd0;
            half_wave_d = 1'b0;
        end else if (blink_cnt_q == c_blink_last) begin
            blink_cnt_d = 32'd0;
            half_wave_d = !half_wave_q;
        end

        if (w_tick) begin
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d  = 6'd0;
                    hour_d = wrap5(hour_q, 1'b1);
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else if (w_edit) begin
            case (state_q)
                ADJ_H:   hour_d = wrap5(hour_q, flag_add);
                ADJ_M:   min_d  = wrap6(min_q, flag_add);
                ADJ_S:   sec_d  = wrap6(sec_q, flag_add);
                default: ;
            endcase
        end

        if (w_edit && state_q == AL_H) al_hour_d = wrap5(al_hour_q, flag_add);
        if (w_edit && state_q == AL_M) al_min_d  = wrap6(al_min_q, flag_add);

        w_trigger = w_tick && armed_q && (sec_d == 6'd0) &&
                    (min_d == al_min_q) && (hour_d == al_hour_q);

        if (ring_q && w_tick) begin
            if (ring_cnt_q <= 8'd1) begin
                ring_d     = 1'b0;
                ring_cnt_d = 8'd0;
            end else begin
                ring_cnt_d = ring_cnt_q - 8'd1;
            end
        end
        if (w_trigger) begin
            ring_d     = 1'b1;
            ring_cnt_d = c_ring_load;
        end

        if (flag_alarm) begin
            if (ring_q) ring_d = 1'b0;
            else        armed_d = !armed_q;
        end
        // Entering ADJ_H silences the alarm even if a trigger lands on the same edge.
        if (flag_alarm && ring_q || (state_q == RUN && flag_adjust)) begin
            ring_d     = 1'b0;
            ring_cnt_d = 8'd0;
        end
    end

    always_comb begin
        w_disp_h     = w_al ? al_hour_q : hour_q;
        w_disp_m     = w_al ? al_min_q : min_q;
        w_disp_s     = w_al ? 6'd0 : sec_q;
        w_disp_h_map = w_disp_h;
        if (h12_q) begin
            if (w_disp_h == 5'd0)      w_disp_h_map = 5'd12;
            else if (w_disp_h > 5'd12) w_disp_h_map = w_disp_h - 5'd12;
        end
        num_d = {to_bcd({1'b0, w_disp_h_map}), to_bcd(w_disp_m), to_bcd(w_disp_s)};
        pm_d  = h12_q && (w_disp_h >= 5'd12);
        hb_d  = half_wave_q && (state_q == ADJ_H || state_q == AL_H);
        mb_d  = half_wave_q && (state_q == ADJ_M || state_q == AL_M);
        sb_d  = half_wave_q && (state_q == ADJ_S);
    end

    always_ff @(posedge clk_25m or posedge rst_25m) begin
        if (rst_25m) begin
            state_q     <= RUN;
            cnt_q       <= 32'd0;
            blink_cnt_q <= 32'd0;
            half_wave_q <= 1'b0;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            hour_q      <= 5'd0;
            al_min_q    <= 6'd0;
            al_hour_q   <= 5'd0;
            armed_q     <= 1'b0;
            ring_q      <= 1'b0;
            ring_cnt_q  <= 8'd0;
            h12_q       <= H12_DEFAULT;
            num_q       <= c_num_rst;
            pm_q        <= 1'b0;
            hb_q        <= 1'b0;
            mb_q        <= 1'b0;
            sb_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            blink_cnt_q <= blink_cnt_d;
            half_wave_q <= half_wave_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            al_min_q    <= al_min_d;
            al_hour_q   <= al_hour_d;
            armed_q     <= armed_d;
            ring_q      <= ring_d;
            ring_cnt_q  <= ring_cnt_d;
            h12_q       <= h12_d;
            num_q       <= num_d;
            pm_q        <= pm_d;
            hb_q        <= hb_d;
            mb_q        <= mb_d;
            sb_q        <= sb_d;
        end
    end

    assign digital_num = num_q;
    assign pm          = pm_q;
    assign h_blink     = hb_q;
    assign m_blink     = mb_q;
    assign s_blink     = sb_q;
    assign alarm_view  = w_al;
    assign alarm_armed = armed_q;
    assign alarm_ring  = ring_q;

endmodule
`default_nettype wire

// File: doc/rtc_alarm_ctrl.md
# rtc_alarm_ctrl

Parametrised time-of-day controller for the VGA digital clock: it keeps hh:mm:ss, sets time and alarm from push-button flags, supports 12/24-hour display and drives a timed alarm output. It sits between the debounced key-flag logic and the VGA digit renderer, and replaces the fixed 24-hour, hour/minute-only controller. Its outputs are registered BCD digits and per-field blink enables.

## Interface
- T_1S, 25_000_000: clk_25m cycles per second tick.
- T_BLINK, 12_500_000: clk_25m cycles per blink half-period.
- RING_S, 60: alarm ring duration in seconds (1..255).
- H12_DEFAULT, 0: display mode after reset (0 = 24 h, 1 = 12 h).
- clk_25m  input  1  system clock; all logic on its rising edge.
- rst_25m  input  1  asynchronous, active-high reset.
- flag_adjust  input  1  one-cycle pulse; advances the edit FSM.
- flag_add  input  1  one-cycle pulse; increments the selected field.
- flag_sub  input  1  one-cycle pulse; decrements the selected field.
- flag_mode  input  1  one-cycle pulse; toggles 12/24-hour display.
- flag_alarm  input  1  one-cycle pulse; stops ringing, otherwise toggles alarm arm.
- digital_num  output  24  BCD {hh, mm, ss}, registered.
- pm  output  1  12 h mode: hour ≥ 12; 0 in 24 h mode.
- h_blink, m_blink, s_blink  output  1 each  1 = renderer blanks that field.
- alarm_view  output  1  1 while in AL_H or AL_M.
- alarm_armed  output  1  alarm arm state.
- alarm_ring  output  1  alarm sounding.

## Operation
- **FSM states:** RUN, ADJ_H, ADJ_M, ADJ_S, AL_H, AL_M.
  - Each flag_adjust advances RUN→ADJ_H→ADJ_M→ADJ_S→AL_H→AL_M→RUN.
  - Reset state is RUN.
- **Tick counter** cnt (32 bit):
  - Counts 0..T_1S-1.
  - tick = (cnt == T_1S-1) in RUN, AL_H and AL_M.
  - In ADJ_* cnt is held at 0, so the time is frozen.
- **Time counters:** sec 0..59 and min 0..59 (6 bit), hour 0..23 (5 bit).
  - On tick, sec increments; the carry ripples sec→min→hour; 23:59:59 wraps to 00:00:00.
- **Editing:** flag_add / flag_sub act on the field selected by the state.
  - ADJ_H/ADJ_M/ADJ_S edit hour/min/sec; AL_H/AL_M edit al_hour/al_min.
  - Each field wraps modulo its range (0→59 on sub, 59→0 on add; hour 23↔0).
  - No carry into other fields during editing.
  - In RUN, add/sub are ignored.
- **Simultaneous flags:**
  - flag_add and flag_sub in the same cycle: no change.
  - flag_adjust with add/sub: the FSM advances and add/sub are ignored.
  - A tick coinciding with RUN→ADJ_H is applied.
- **Display selection:** digital_num shows the time, except in AL_H/AL_M where it shows {al_hour, al_min, 00}.
- **12-hour mapping:** hour 0→12, 1..12 unchanged, 13..23→1..11; pm = (hour ≥ 12).
  - The alarm view uses the same mapping.
- **Display mode:** flag_mode toggles h12 in any state.
- **Blink:**
  - cnt_blink counts 0..T_BLINK-1; half_wave toggles at terminal count.
  - On flag_adjust, cnt_blink and half_wave clear to 0, so the new field is shown on entry.
  - x_blink = half_wave & (state selects x). AL_H selects h_blink, AL_M selects m_blink.
  - All blinks are 0 in RUN.
- **Alarm trigger:**
  - Condition: a tick produces sec = 0 with hour == al_hour and min == al_min, while alarm_armed = 1 and state ≠ ADJ_*.
  - Then alarm_ring = 1 and ring_cnt loads RING_S.
- **Alarm end:** while ringing, each tick decrements ring_cnt; ring clears when ring_cnt reaches 0, on flag_alarm, or on entry to ADJ_H.
- **flag_alarm:** while ringing it stops the ring and leaves alarm_armed unchanged; otherwise it toggles alarm_armed.
- **BCD conversion:** binary→BCD per field is combinational; digital_num, pm and the blink outputs are registered.
- **Reset values:**
  - Time 00:00:00, alarm 00:00, alarm_armed 0, alarm_ring 0, state RUN, h12 = H12_DEFAULT.
  - All counters 0, half_wave 0.
  - digital_num 24'h000000 in 24 h mode (24'h120000 if H12_DEFAULT = 1), pm 0, all blinks 0.

## Timing
- **Output latency:** a counter update at edge N appears on digital_num, pm and the blinks at edge N+1.
- **First tick:** T_1S cycles after reset release, then every T_1S cycles while not in ADJ_*.
- **Resume after ADJ_S:** the first tick after ADJ_S→AL_H comes exactly T_1S cycles after that transition.
- **Edit latency:** an add/sub pulse at edge N changes the field at N; it is visible at N+1.
- **Alarm ring:** alarm_ring rises at the edge after the triggering tick and lasts RING_S ticks.
- **Blink:** half_wave toggles every T_BLINK cycles; the blink period is 2·T_BLINK.
- **Reset:** asserting rst_25m mid-operation returns all state to reset values immediately (asynchronous). Release is synchronous to clk_25m.

## Test plan
All scenarios use T_1S = 10, T_BLINK = 4, RING_S = 3.

- **Rollover:** preset 23:59:58 via edits, return to RUN, run 20 cycles → digital_num 24'h000000 after the second tick.
- **12-hour mode:** set hour 13, pulse flag_mode → digital_num[23:16] = 8'h01, pm = 1; set hour 0 → 8'h12, pm = 0.
- **Edit wrap:** in ADJ_M at min 0, pulse flag_sub → min 59 and hour unchanged; add and sub together → no change; time frozen for 100 cycles.
- **Blink:** enter ADJ_H → h_blink = 0 for 4 cycles, then 1 for 4 cycles; m_blink and s_blink stay 0; in AL_M only m_blink toggles and alarm_view = 1.
- **Alarm ring:** alarm 00:01, armed, time 00:00:59 → alarm_ring rises 1 cycle after the tick giving 00:01:00 and falls after 3 ticks. A flag_alarm mid-ring clears it with alarm_armed still 1.
- **Mid-operation reset:** pulse rst_25m during ADJ_S with the ring active → all outputs at reset values immediately; the first tick comes 10 cycles after release.
